// File: rtl/cam_green_pixel_counter.sv
// Camera front end: syncs an OV-style byte bus into clk, pairs bytes into RGB565 pixels,
// flags green pixels and reports saturating per-frame pixel/green counts.
`timescale 1ns/1ps
module cam_green_pixel_counter #(
  parameter int         CNT_W = 16,
  parameter logic [5:0] G_MIN = 6'd32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             capture_en,
  input  logic             cam_pclk,
  input  logic             cam_href,
  input  logic             cam_vsync,
  input  logic [7:0]       cam_data,
  output logic             pix_valid,
  output logic [15:0]      pix_data,
  output logic             pix_green,
  output logic             frame_valid,
  output logic [CNT_W-1:0] pixel_count,
  output logic [CNT_W-1:0] green_count,
  output logic             frame_err,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACTIVE = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state_q, state_d;

  // bit0/bit1 form the synchronizer, bit2 is the history used for edge detection
  logic [2:0] pclk_q, href_q, vsync_q;
  logic [7:0] data_s1_q, data_s2_q;

  logic             phase_q, phase_d;
  logic [7:0]       hi_q, hi_d;
  logic [15:0]      word_q, word_d;
  logic             word_stb_q, word_stb_d;
  logic [CNT_W-1:0] run_pix_q, run_pix_d;
  logic [CNT_W-1:0] run_green_q, run_green_d;
  logic             run_err_q, run_err_d;

  logic             pix_valid_q, pix_green_q, frame_valid_q, frame_err_q;
  logic [15:0]      pix_data_q;
  logic [CNT_W-1:0] pixel_count_q, green_count_q;

  logic pclk_rise, href_fall, vsync_rise, vsync_fall, byte_stb;
  logic busy_c, start_c, done_c, green_c;
  logic [5:0] g6, r6, b6;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pclk_q    <= '0;
      href_q    <= '0;
      vsync_q   <= '0;
      data_s1_q <= '0;
      data_s2_q <= '0;
    end else begin
      pclk_q    <= {pclk_q[1:0], cam_pclk};
      href_q    <= {href_q[1:0], cam_href};
      vsync_q   <= {vsync_q[1:0], cam_vsync};
      data_s1_q <= cam_data;
      data_s2_q <= data_s1_q;
    end
  end

  assign pclk_rise  =  pclk_q[1]  & ~pclk_q[2];
  assign href_fall  = ~href_q[1]  &  href_q[2];
  assign vsync_rise =  vsync_q[1] & ~vsync_q[2];
  assign vsync_fall = ~vsync_q[1] &  vsync_q[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (capture_en && vsync_fall) state_d = S_ACTIVE;
      S_ACTIVE: begin
        if (!capture_en)     state_d = S_IDLE;
        else if (vsync_rise) state_d = S_DONE;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_c  = (state_q == S_ACTIVE);
    start_c = (state_q == S_IDLE) && (state_d == S_ACTIVE);
    done_c  = (state_q == S_DONE);
  end

  assign byte_stb = busy_c && pclk_rise && href_q[1];

  assign g6      = word_q[10:5];
  assign r6      = {word_q[15:11], 1'b0};
  assign b6      = {word_q[4:0], 1'b0};
  assign green_c = (g6 >= G_MIN) && (g6 > r6) && (g6 > b6);

  always_comb begin
    phase_d     = phase_q;
    hi_d        = hi_q;
    word_d      = word_q;
    word_stb_d  = 1'b0;
    run_pix_d   = run_pix_q;
    run_green_d = run_green_q;
    run_err_d   = run_err_q;
    if (start_c) begin
      phase_d     = 1'b0;
      run_pix_d   = '0;
      run_green_d = '0;
      run_err_d   = 1'b0;
    end else begin
      if (byte_stb) begin
        phase_d = ~phase_q;
        if (!phase_q) begin
          hi_d = data_s2_q;
        end else begin
          word_d     = {hi_q, data_s2_q};
          word_stb_d = 1'b1;
        end
      end else if (busy_c && href_fall && phase_q) begin
        phase_d   = 1'b0;
        run_err_d = 1'b1;
      end
      // the count lands on the same edge pix_valid rises, so a coincident vsync rise sees it
      if (word_stb_q) begin
        if (run_pix_q == CNT_MAX) run_err_d = 1'b1;
        else                      run_pix_d = run_pix_q + CNT_ONE;
        if (green_c) begin
          if (run_green_q == CNT_MAX) run_err_d   = 1'b1;
          else                        run_green_d = run_green_q + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q       <= 1'b0;
      hi_q          <= '0;
      word_q        <= '0;
      word_stb_q    <= 1'b0;
      run_pix_q     <= '0;
      run_green_q   <= '0;
      run_err_q     <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_data_q    <= '0;
      pix_green_q   <= 1'b0;
      frame_valid_q <= 1'b0;
      pixel_count_q <= '0;
      green_count_q <= '0;
      frame_err_q   <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      hi_q          <= hi_d;
      word_q        <= word_d;
      word_stb_q    <= word_stb_d;
      run_pix_q     <= run_pix_d;
      run_green_q   <= run_green_d;
      run_err_q     <= run_err_d;
      pix_valid_q   <= word_stb_q;
      if (word_stb_q) begin
        pix_data_q  <= word_q;
        pix_green_q <= green_c;
      end
      frame_valid_q <= done_c;
      if (done_c) begin
        pixel_count_q <= run_pix_d;
        green_count_q <= run_green_d;
        frame_err_q   <= run_err_d;
      end
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_data    = pix_data_q;
  assign pix_green   = pix_green_q;
  assign frame_valid = frame_valid_q;
  assign pixel_count = pixel_count_q;
  assign green_count = green_count_q;
  assign frame_err   = frame_err_q;
  assign busy        = busy_c;

endmodule

// File: tb/tb_cam_green_pixel_counter.sv
// Bench for cam_green_pixel_counter: a wide-counter instance and a CNT_W=4 instance share
// one camera bus; a frame-level reference model supplies expected pixels and counts.
`timescale 1ns/1ps
module tb_cam_green_pixel_counter;

  logic        clk = 1'b0;
  logic        rst_n, capture_en, cam_pclk, cam_href, cam_vsync;
  logic [7:0]  cam_data;

  logic        pix_valid, pix_green, frame_valid, frame_err, busy;
  logic [15:0] pix_data, pixel_count, green_count;
  logic        pix_valid4, pix_green4, frame_valid4, frame_err4, busy4;
  logic [15:0] pix_data4;
  logic [3:0]  pixel_count4, green_count4;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  cam_green_pixel_counter #(.CNT_W(16), .G_MIN(6'd32)) u_dut (
    .clk(clk), .rst_n(rst_n), .capture_en(capture_en), .cam_pclk(cam_pclk),
    .cam_href(cam_href), .cam_vsync(cam_vsync), .cam_data(cam_data),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_green(pix_green),
    .frame_valid(frame_valid), .pixel_count(pixel_count), .green_count(green_count),
    .frame_err(frame_err), .busy(busy));

  cam_green_pixel_counter #(.CNT_W(4), .G_MIN(6'd32)) u_sat (
    .clk(clk), .rst_n(rst_n), .capture_en(capture_en), .cam_pclk(cam_pclk),
    .cam_href(cam_href), .cam_vsync(cam_vsync), .cam_data(cam_data),
    .pix_valid(pix_valid4), .pix_data(pix_data4), .pix_green(pix_green4),
    .frame_valid(frame_valid4), .pixel_count(pixel_count4), .green_count(green_count4),
    .frame_err(frame_err4), .busy(busy4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // observed traffic, collected away from the active edge
  logic [16:0] obs_pix[$];
  int          obs_cyc[$];
  logic [32:0] obs_frm[$];
  logic [8:0]  obs_frm4[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (pix_valid) begin
        obs_pix.push_back({pix_green, pix_data});
        obs_cyc.push_back(cyc);
      end
      if (frame_valid)  obs_frm.push_back({frame_err, green_count, pixel_count});
      if (frame_valid4) obs_frm4.push_back({frame_err4, green_count4, pixel_count4});
    end
  end

  // frame description and reference model results
  logic [7:0]  fr_bytes[$];
  int          fr_lens[$];
  int          rise_cyc[$];
  logic [16:0] exp_pix[$];
  logic [32:0] exp_frm;
  logic [8:0]  exp_frm4;

  function automatic bit ref_green(input logic [15:0] p);
    int r, g, b;
    r = int'(p) / 2048;
    g = (int'(p) / 32) % 64;
    b = int'(p) % 32;
    return (g >= 32) && (g > 2 * r) && (g > 2 * b);
  endfunction

  task automatic model_frame();
    int idx = 0;
    int npix = 0;
    int ng = 0;
    bit odd = 1'b0;
    logic [15:0] p;
    exp_pix.delete();
    foreach (fr_lens[l]) begin
      for (int j = 0; j + 1 < fr_lens[l]; j += 2) begin
        p = {fr_bytes[idx + j], fr_bytes[idx + j + 1]};
        exp_pix.push_back({ref_green(p), p});
        npix++;
        if (ref_green(p)) ng++;
      end
      if (fr_lens[l] % 2 == 1) odd = 1'b1;
      idx += fr_lens[l];
    end
    exp_frm  = {odd || npix > 65535 || ng > 65535,
                16'(ng > 65535 ? 65535 : ng), 16'(npix > 65535 ? 65535 : npix)};
    exp_frm4 = {odd || npix > 15 || ng > 15, 4'(ng > 15 ? 15 : ng), 4'(npix > 15 ? 15 : npix)};
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drive_byte(input logic [7:0] b);
    cam_data = b;
    tick(3);
    cam_pclk = 1'b1;
    rise_cyc.push_back(cyc);
    tick(3);
    cam_pclk = 1'b0;
  endtask

  task automatic drive_line(input int idx, input int len);
    cam_href = 1'b1;
    tick(2);
    for (int j = 0; j < len; j++) drive_byte(fr_bytes[idx + j]);
    tick(2);
    cam_href = 1'b0;
    tick(4);
  endtask

  task automatic frame_start();
    cam_vsync = 1'b1;
    tick(6);
    cam_vsync = 1'b0;
    tick(6);
  endtask

  task automatic frame_end();
    cam_vsync = 1'b1;
    tick(10);
  endtask

  task automatic send_frame();
    int idx = 0;
    model_frame();
    obs_pix.delete(); obs_cyc.delete(); obs_frm.delete(); obs_frm4.delete(); rise_cyc.delete();
    frame_start();
    foreach (fr_lens[l]) begin
      drive_line(idx, fr_lens[l]);
      idx += fr_lens[l];
    end
    frame_end();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; capture_en = 1'b1; cam_pclk = 1'b0; cam_href = 1'b0;
    cam_vsync = 1'b1; cam_data = 8'h00;
    tick(3);
    checks++;
    if ({pix_valid, pix_data, pix_green, frame_valid, pixel_count, green_count, frame_err, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %0b/%h/%0b/%0b/%0d/%0d/%0b/%0b want all zero", pix_valid, pix_data,
               pix_green, frame_valid, pixel_count, green_count, frame_err, busy);
    end
    checks++;
    if ({pix_valid4, pix_data4, pix_green4, frame_valid4, pixel_count4, green_count4, frame_err4, busy4} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_sat: got pc=%0d gc=%0d data=%h busy=%0b want all zero",
               pixel_count4, green_count4, pix_data4, busy4);
    end
    rst_n = 1'b1;
    tick(3);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy got %0b want 0", busy);
    end
  endtask

  task automatic test_uniform();
    fr_bytes.delete(); fr_lens.delete();
    for (int l = 0; l < 10; l++) begin
      fr_bytes.push_back(8'h3C); fr_bytes.push_back(8'hA0); fr_lens.push_back(2);
    end
    send_frame();
    checks++;
    if (obs_pix.size() != 10) begin
      errors++; $display("FAIL uniform_strobes: got %0d want 10", obs_pix.size());
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (i >= obs_pix.size() || obs_pix[i] !== 17'h13CA0) begin
        errors++;
        $display("FAIL uniform_pixel[%0d]: got %h want 13ca0", i, (i < obs_pix.size()) ? obs_pix[i] : 17'hx);
      end
    end
    checks++;
    if (obs_cyc.size() == 0 || rise_cyc.size() < 2 || obs_cyc[0] - rise_cyc[1] != 4) begin
      errors++;
      $display("FAIL uniform_latency: got %0d want 4", (obs_cyc.size() > 0 && rise_cyc.size() > 1) ? obs_cyc[0] - rise_cyc[1] : -1);
    end
    checks++;
    if (obs_frm.size() != 1) begin
      errors++; $display("FAIL uniform_frame_strobes: got %0d want 1", obs_frm.size());
    end
    checks++;
    if (pixel_count !== 16'd10 || green_count !== 16'd10 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL uniform_counts: got pc=%0d gc=%0d err=%0b want 10 10 0", pixel_count, green_count, frame_err);
    end
    checks++;
    if (obs_frm.size() == 0 || obs_frm[0] !== exp_frm) begin
      errors++; $display("FAIL uniform_model: got %h want %h", (obs_frm.size() > 0) ? obs_frm[0] : 33'hx, exp_frm);
    end
  endtask

  task automatic test_patterns();
    logic [7:0] pat[8] = '{8'h3C, 8'hA0, 8'hF8, 8'h00, 8'h07, 8'hE0, 8'h04, 8'h00};
    fr_bytes.delete(); fr_lens.delete();
    foreach (pat[i]) fr_bytes.push_back(pat[i]);
    fr_lens.push_back(4); fr_lens.push_back(4);
    send_frame();
    checks++;
    if (obs_pix.size() != exp_pix.size()) begin
      errors++; $display("FAIL patterns_strobes: got %0d want %0d", obs_pix.size(), exp_pix.size());
    end
    foreach (exp_pix[i]) begin
      checks++;
      if (i >= obs_pix.size() || obs_pix[i] !== exp_pix[i]) begin
        errors++;
        $display("FAIL patterns_pixel[%0d]: got %h want %h", i, (i < obs_pix.size()) ? obs_pix[i] : 17'hx, exp_pix[i]);
      end
    end
    checks++;
    if (obs_frm.size() != 1 || obs_frm[0] !== exp_frm) begin
      errors++; $display("FAIL patterns_frame: got %h (n=%0d) want %h", {frame_err, green_count, pixel_count}, obs_frm.size(), exp_frm);
    end
  endtask

  task automatic test_odd_line();
    fr_bytes.delete(); fr_lens.delete();
    fr_bytes.push_back(8'h3C); fr_bytes.push_back(8'hA0); fr_bytes.push_back(8'h11);
    fr_lens.push_back(3);
    send_frame();
    checks++;
    if (obs_pix.size() != 1 || obs_pix[0] !== 17'h13CA0) begin
      errors++; $display("FAIL odd_line_pixels: got n=%0d want 1 pixel 13ca0", obs_pix.size());
    end
    checks++;
    if (obs_frm.size() != 1 || pixel_count !== 16'd1 || frame_err !== 1'b1) begin
      errors++;
      $display("FAIL odd_line_frame: got n=%0d pc=%0d err=%0b want 1 1 1", obs_frm.size(), pixel_count, frame_err);
    end
  endtask

  task automatic test_abort();
    logic [32:0] prev_frm;
    prev_frm = exp_frm;
    fr_bytes.delete(); fr_lens.delete();
    for (int i = 0; i < 5; i++) begin
      fr_bytes.push_back(8'h07); fr_bytes.push_back(8'hE0);
    end
    fr_lens.push_back(10);
    model_frame();
    obs_pix.delete(); obs_frm.delete(); obs_frm4.delete();
    frame_start();
    cam_href = 1'b1;
    tick(2);
    for (int j = 0; j < 10; j++) drive_byte(fr_bytes[j]);
    tick(3);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL abort_busy_before: got %0b want 1", busy);
    end
    capture_en = 1'b0;
    tick(1);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL abort_busy_after: got %0b want 0", busy);
    end
    cam_href = 1'b0;
    tick(4);
    frame_end();
    capture_en = 1'b1;
    checks++;
    if (obs_pix.size() != 5) begin
      errors++; $display("FAIL abort_strobes: got %0d want 5", obs_pix.size());
    end
    checks++;
    if (obs_frm.size() != 0 || obs_frm4.size() != 0) begin
      errors++; $display("FAIL abort_frame_valid: got %0d want 0", obs_frm.size());
    end
    checks++;
    if ({frame_err, green_count, pixel_count} !== prev_frm) begin
      errors++; $display("FAIL abort_hold: got %h want %h", {frame_err, green_count, pixel_count}, prev_frm);
    end
  endtask

  task automatic test_saturation();
    int npix[2] = '{15, 20};
    logic [8:0] want4[2] = '{9'h0FF, 9'h1FF};
    for (int k = 0; k < 2; k++) begin
      fr_bytes.delete(); fr_lens.delete();
      for (int i = 0; i < npix[k]; i++) begin
        fr_bytes.push_back(8'h07); fr_bytes.push_back(8'hE0);
      end
      fr_lens.push_back(2 * npix[k] - 10); fr_lens.push_back(10);
      send_frame();
      checks++;
      if (obs_frm4.size() != 1 || obs_frm4[0] !== want4[k]) begin
        errors++;
        $display("FAIL sat_small[%0d]: got pc=%0d gc=%0d err=%0b want %h", npix[k], pixel_count4, green_count4, frame_err4, want4[k]);
      end
      checks++;
      if (obs_frm4.size() != 1 || obs_frm4[0] !== exp_frm4) begin
        errors++; $display("FAIL sat_small_model[%0d]: got %h want %h", npix[k], (obs_frm4.size() > 0) ? obs_frm4[0] : 9'hx, exp_frm4);
      end
      checks++;
      if (obs_frm.size() != 1 || pixel_count !== 16'(npix[k]) || frame_err !== 1'b0) begin
        errors++; $display("FAIL sat_wide[%0d]: got pc=%0d err=%0b want %0d 0", npix[k], pixel_count, frame_err, npix[k]);
      end
    end
  endtask

  task automatic test_reset_mid_line();
    frame_start();
    cam_href = 1'b1;
    tick(2);
    drive_byte(8'h3C); drive_byte(8'hA0); drive_byte(8'h07);
    cam_data = 8'hE0;
    cam_pclk = 1'b1;
    tick(1);
    checks++;
    if (busy !== 1'b1 || pixel_count == 16'd0) begin
      errors++; $display("FAIL rst_mid_precond: got busy=%0b pc=%0d want 1 nonzero", busy, pixel_count);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({pix_valid, pix_data, pix_green, frame_valid, pixel_count, green_count, frame_err, busy} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got pc=%0d gc=%0d data=%h busy=%0b want all zero", pixel_count, green_count, pix_data, busy);
    end
    cam_pclk = 1'b0; cam_href = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    fr_bytes.delete(); fr_lens.delete();
    for (int i = 0; i < 6; i++) begin
      fr_bytes.push_back(8'h3C); fr_bytes.push_back(8'hA0);
    end
    fr_bytes.push_back(8'hF8); fr_bytes.push_back(8'h00);
    fr_lens.push_back(8); fr_lens.push_back(6);
    send_frame();
    checks++;
    if (obs_frm.size() != 1 || pixel_count !== 16'd7 || green_count !== 16'd6 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_next_frame: got n=%0d pc=%0d gc=%0d err=%0b want 1 7 6 0", obs_frm.size(), pixel_count, green_count, frame_err);
    end
  endtask

  task automatic test_random();
    logic [7:0] greenish[4] = '{8'h07, 8'hE0, 8'h3C, 8'hA0};
    int nl;
    for (int f = 0; f < 8; f++) begin
      fr_bytes.delete(); fr_lens.delete();
      nl = $urandom_range(1, 4);
      for (int l = 0; l < nl; l++) begin
        fr_lens.push_back($urandom_range(0, 9));
        for (int j = 0; j < fr_lens[l]; j++)
          fr_bytes.push_back(($urandom_range(0, 1) == 1) ? greenish[$urandom_range(0, 3)] : 8'($urandom_range(0, 255)));
      end
      send_frame();
      checks++;
      if (obs_pix.size() != exp_pix.size()) begin
        errors++; $display("FAIL random[%0d]_strobes: got %0d want %0d", f, obs_pix.size(), exp_pix.size());
      end
      foreach (exp_pix[i]) begin
        checks++;
        if (i >= obs_pix.size() || obs_pix[i] !== exp_pix[i]) begin
          errors++;
          $display("FAIL random[%0d]_pixel[%0d]: got %h want %h", f, i, (i < obs_pix.size()) ? obs_pix[i] : 17'hx, exp_pix[i]);
        end
      end
      checks++;
      if (obs_frm.size() != 1 || obs_frm[0] !== exp_frm) begin
        errors++; $display("FAIL random[%0d]_frame: got %h (n=%0d) want %h", f, {frame_err, green_count, pixel_count}, obs_frm.size(), exp_frm);
      end
      checks++;
      if (obs_frm4.size() != 1 || obs_frm4[0] !== exp_frm4) begin
        errors++; $display("FAIL random[%0d]_frame_sat: got %h want %h", f, {frame_err4, green_count4, pixel_count4}, exp_frm4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_patterns();
    test_odd_line();
    test_abort();
    test_saturation();
    test_reset_mid_line();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
